// File: rtl/eth_mdio_ctrl.sv
// Clause-22 MDIO management master for the RMII PHY (eth_clk domain).
// Optional feature macro: ETH_MDIO_LINK_POLL_EN (autonomous BMSR link poll).
//
// Ports:
//   clk, rstn        : 50 MHz eth_clk, synchronous active-low reset
//   eth_rst          : PHY held in reset; controller idles, aborts frames
//   req_*            : host request (valid/ready), write flag, REGAD, data
//   rsp_valid/rdata  : one-cycle completion pulse, read data (0 on writes)
//   link_up          : last polled BMSR[2] (0 without the macro)
//   ETH_MDC/MDIO_*   : management clock and tristate MDIO pad signals
module eth_mdio_ctrl #(
    parameter int         CLK_DIV     = 10,
    parameter logic [4:0] PHY_ADDR    = 5'd1,
    parameter int         POLL_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        eth_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_reg,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        link_up,
    output logic        ETH_MDC,
    output logic        ETH_MDIO_O,
    output logic        ETH_MDIO_T,
    input  logic        ETH_MDIO_I
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    if (CLK_DIV < 2 || POLL_CYCLES < 1) begin : g_param_chk
        $error("eth_mdio_ctrl: illegal CLK_DIV or POLL_CYCLES");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0] div_q;
    logic          phase_q;
    logic [5:0]    bit_q;
    logic [62:0]   frame_q;
    logic          rd_q;
    logic [15:0]   shift_q;
    logic          mdc_q, mdo_q, mdt_q;
    logic [15:0]   rdata_q;
    logic          poll_q;
    logic          link_q;

    logic          half_end, bit_end, frame_end;
    logic          start_host, start_poll, start;
    logic          new_rd;
    logic [4:0]    new_reg;
    logic [15:0]   new_wdata;
    logic [63:0]   frame_new;

    assign req_ready  = (state_q == IDLE) & ~eth_rst & rstn;
    assign start_host = req_ready & req_valid;
    assign start      = start_host | start_poll;

    assign half_end  = (div_q == DIV_LAST);
    assign bit_end   = (state_q == SHIFT) & phase_q & half_end;
    assign frame_end = bit_end & (bit_q == 6'd63);

    assign ETH_MDC    = mdc_q;
    assign ETH_MDIO_O = mdo_q;
    assign ETH_MDIO_T = mdt_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_valid  = (state_q == DONE) & ~poll_q;
    assign link_up    = link_q;

`ifdef ETH_MDIO_LINK_POLL_EN
    logic [31:0] timer_q;
    logic        pend_q;

    // Host requests win in IDLE; a poll only starts on an idle bus.
    assign start_poll = (state_q == IDLE) & ~req_valid & pend_q
                      & ~eth_rst & rstn;

    always_ff @(posedge clk) begin
        if (!rstn || eth_rst) begin
            timer_q <= 32'(POLL_CYCLES - 1);
            pend_q  <= 1'b0;
        end else begin
            if (start_poll)
                pend_q <= 1'b0;
            if (timer_q == 32'd0) begin
                pend_q  <= 1'b1;
                timer_q <= 32'(POLL_CYCLES - 1);
            end else begin
                timer_q <= timer_q - 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || eth_rst)
            poll_q <= 1'b0;
        else if (start)
            poll_q <= start_poll;
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            link_q <= 1'b0;
        else if (frame_end && !eth_rst && poll_q)
            link_q <= shift_q[2];
    end
`else
    assign start_poll = 1'b0;
    assign poll_q     = 1'b0;
    assign link_q     = 1'b0;
`endif

    // Frame image, bit 0 of the wire at the MSB.
    always_comb begin
        new_rd    = 1'b1;
        new_reg   = 5'd1;
        new_wdata = 16'hFFFF;
        if (start_host) begin
            new_rd    = ~req_write;
            new_reg   = req_reg;
            new_wdata = req_write ? req_wdata : 16'hFFFF;
        end
        frame_new = {32'hFFFF_FFFF, 2'b01,
                     new_rd ? 2'b10 : 2'b01,
                     PHY_ADDR, new_reg,
                     new_rd ? 2'b11 : 2'b10,
                     new_wdata};
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (frame_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (eth_rst)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= 6'd0;
            frame_q <= '1;
            rd_q    <= 1'b0;
            shift_q <= 16'd0;
            mdc_q   <= 1'b0;
            mdo_q   <= 1'b1;
            mdt_q   <= 1'b1;
        end else if (eth_rst) begin
            div_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= 6'd0;
            mdc_q   <= 1'b0;
            mdo_q   <= 1'b1;
            mdt_q   <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        div_q   <= '0;
                        phase_q <= 1'b0;
                        bit_q   <= 6'd0;
                        frame_q <= frame_new[62:0];
                        rd_q    <= new_rd;
                        mdc_q   <= 1'b0;
                        mdo_q   <= frame_new[63];
                        mdt_q   <= 1'b0;
                    end
                end
                SHIFT: begin
                    div_q <= half_end ? '0 : div_q + 1'b1;
                    if (half_end)
                        phase_q <= ~phase_q;
                    // Last low cycle: raise MDC, capture read data.
                    if (half_end && !phase_q) begin
                        mdc_q <= 1'b1;
                        if (bit_q >= 6'd48)
                            shift_q <= {shift_q[14:0], ETH_MDIO_I};
                    end
                    if (bit_end) begin
                        mdc_q <= 1'b0;
                        if (frame_end) begin
                            mdo_q <= 1'b1;
                            mdt_q <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 6'd1;
                            frame_q <= {frame_q[61:0], 1'b1};
                            mdo_q   <= frame_q[62];
                            // Reads release the pad from TA onwards.
                            mdt_q   <= rd_q & (bit_q >= 6'd45);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            rdata_q <= 16'd0;
        else if (frame_end && !eth_rst && !poll_q)
            rdata_q <= rd_q ? shift_q : 16'd0;
    end

endmodule
